// File: rtl/fp8_mac_sequencer.sv
// Sequenced E4M3 multiply-accumulate: a job of len (a,b) pairs is folded into one
// accumulator through a single combinational FMA, and the result is held until taken.

// Exact E4M3 fused multiply-add y = a*b + c with one round-to-nearest-even.
// Every encoding is finite; results beyond the largest magnitude clamp to 0x7F/0xFF.
module fp8_e4m3_fma (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [7:0] c_i,
    output logic [7:0] y_o
);
    // All operands and the exact sum are kept as integers in units of 2^-18.
    localparam int MW     = 38;
    localparam int NORM_P = 12;

    logic [3:0]    sig_a, sig_b, sig_c;
    logic [3:0]    exp_a, exp_b, exp_c;
    logic [7:0]    prod_sig;
    logic [5:0]    prod_sh, c_sh;
    logic [MW-1:0] prod_mag, c_mag, sum_mag;
    logic          prod_sgn, sum_sgn;
    logic [5:0]    lead;
    logic [5:0]    rnd_sh;
    logic [3:0]    kept;
    logic [MW-1:0] rem_mask;
    logic          guard, sticky, round_up;
    logic [9:0]    base, code;

    function automatic logic [3:0] eff_exp(input logic [7:0] v);
        return (v[6:3] == 4'd0) ? 4'd1 : v[6:3];
    endfunction

    always_comb begin
        sig_a    = {|a_i[6:3], a_i[2:0]};
        sig_b    = {|b_i[6:3], b_i[2:0]};
        sig_c    = {|c_i[6:3], c_i[2:0]};
        exp_a    = eff_exp(a_i);
        exp_b    = eff_exp(b_i);
        exp_c    = eff_exp(c_i);

        prod_sig = {4'd0, sig_a} * {4'd0, sig_b};
        prod_sh  = {2'd0, exp_a} + {2'd0, exp_b} - 6'd2;
        c_sh     = {2'd0, exp_c} + 6'd8;
        prod_mag = {{(MW-8){1'b0}}, prod_sig} << prod_sh;
        c_mag    = {{(MW-4){1'b0}}, sig_c} << c_sh;
        prod_sgn = a_i[7] ^ b_i[7];

        if (prod_sgn == c_i[7]) begin
            sum_mag = prod_mag + c_mag;
            sum_sgn = prod_sgn;
        end else if (prod_mag >= c_mag) begin
            sum_mag = prod_mag - c_mag;
            sum_sgn = prod_sgn;
        end else begin
            sum_mag = c_mag - prod_mag;
            sum_sgn = c_i[7];
        end
        // Exact cancellation yields +0.
        if ((sum_mag == '0) && (prod_sgn != c_i[7])) begin
            sum_sgn = 1'b0;
        end

        lead = 6'd0;
        for (int i = 0; i < MW; i++) begin
            if (sum_mag[i]) begin
                lead = 6'(i);
            end
        end

        // Normals keep four significant bits; subnormals have a fixed 2^-9 quantum.
        rnd_sh   = (lead >= 6'(NORM_P)) ? (lead - 6'd3) : 6'd9;
        kept     = 4'(sum_mag >> rnd_sh);
        guard    = sum_mag[rnd_sh - 6'd1];
        rem_mask = (MW'(1) << (rnd_sh - 6'd1)) - MW'(1);
        sticky   = |(sum_mag & rem_mask);
        round_up = guard & (sticky | kept[0]);

        // A rounding carry out of the significand rolls into the exponent field.
        base = (lead >= 6'(NORM_P)) ? ((10'(lead) - 10'd12) << 3) : 10'd0;
        code = base + {6'd0, kept} + {9'd0, round_up};
        y_o  = {sum_sgn, (code > 10'd127) ? 7'h7F : code[6:0]};
    end
endmodule

module fp8_mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       acc_init,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sat,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and a presented result holds until taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e           state_q;
    logic [7:0]       acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic             sat_q;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [7:0]       acc_d;
    logic [LEN_W-1:0] cnt_d;
    logic             sat_d;
    logic             beat;

    fp8_e4m3_fma u_fma (
        .a_i (in_a),
        .b_i (in_b),
        .c_i (acc_q),
        .y_o (acc_d)
    );

    assign beat  = in_valid & in_ready_q;
    assign cnt_d = cnt_q - LEN_W'(1);
    assign sat_d = sat_q | (acc_d[6:0] == 7'h7F);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 8'h00;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (abort) begin
            // acc, cnt and sat are left as they are; only the job is dropped.
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= acc_init;
                        cnt_q  <= len;
                        sat_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        sat_q <= sat_d;
                        // RUN is only entered with cnt >= 1, so cnt never wraps.
                        if (cnt_q == LEN_W'(1)) begin
                            state_q     <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_sat   = sat_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !abort) |=> (out_valid && $stable(out_data) && $stable(out_sat)));
    a_ready_in_run: assert property (@(posedge clk) disable iff (rst)
        in_ready |-> (state_q == RUN));
endmodule

// File: doc/fp8_mac_sequencer.md
FP8_MAC_SEQUENCER -- requirements
Module: fp8_mac_sequencer

Interface
REQ-001 Parameter SHALL be: LEN_W, 8, width of the job length field and the element counter.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  job request, sampled only in IDLE.
REQ-005 len  input  LEN_W  number of (a,b) pairs in the job, sampled with start.
REQ-006 acc_init  input  8  initial E4M3 accumulator value, sampled with start.
REQ-007 abort  input  1  synchronous job cancel.
REQ-008 in_valid  input  1  element pair valid.
REQ-009 in_ready  output  1  sequencer accepts an element pair.
REQ-010 in_a, in_b  input  8 each  E4M3 operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  8  E4M3 accumulated result.
REQ-014 out_sat  output  1  at least one accumulation step of this job produced magnitude 0x7F.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The block SHALL instantiate exactly one combinational fp8_e4m3_fma unit with a=in_a, b=in_b, c=acc; it SHALL NOT modify the unit's arithmetic.
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and OUT.
REQ-018 In IDLE, start=1 SHALL load acc<=acc_init, cnt<=len and sat<=0.
REQ-019 From IDLE with start=1, the next state SHALL be OUT when len==0 and RUN otherwise.
REQ-020 In RUN, in_ready SHALL be 1; in IDLE and OUT it SHALL be 0.
REQ-021 A beat SHALL occur when in_valid and in_ready are both high.
REQ-022 On each beat: acc<=fma result; cnt<=cnt-1; sat<=sat OR (fma result[6:0]==7'h7F).
REQ-023 Throughput SHALL be one beat per cycle; in_valid low in RUN SHALL hold all state.
REQ-024 A beat with cnt==1 SHALL transition to OUT; out_valid SHALL rise the cycle after that beat.
REQ-025 In OUT: out_valid=1, out_data=acc, out_sat=sat; all three SHALL remain stable until out_ready=1.
REQ-026 out_valid and out_ready both high in OUT SHALL return the FSM to IDLE next cycle.
REQ-027 When not in OUT, out_valid SHALL be 0 and out_data, out_sat SHALL show current acc, sat.
REQ-028 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-029 An IDLE start in the same cycle as the OUT->IDLE handshake SHALL be ignored, because the FSM is not yet in IDLE.
REQ-030 abort=1 SHALL force IDLE next cycle from any state, discarding any pending result and any same-cycle beat.
REQ-031 abort SHALL take priority over start, beats and the output handshake; acc and sat SHALL keep their values.
REQ-032 A job with len=2^LEN_W-1 SHALL complete normally; cnt SHALL never wrap below 0.

Reset
REQ-033 While rst=1: FSM=IDLE, acc=8'h00, cnt=0, sat=0, so in_ready=0, out_valid=0, busy=0, out_data=8'h00, out_sat=0.
REQ-034 Reset mid-job SHALL drop the job entirely; no result SHALL be emitted after rst deasserts.

Verification
REQ-035 Basic dot product: start, len=2, acc_init=0x00; beats (0x38,0x38),(0x38,0x38) back-to-back -> acc 0x38 then 0x40; out_valid one cycle after 2nd beat, out_data=0x40, out_sat=0.
REQ-036 Zero-length job: start, len=0, acc_init=0x40 -> in_ready stays 0; out_valid next cycle; out_data=0x40, out_sat=0.
REQ-037 Saturation: len=1, acc_init=0x00, beat (0x7F,0x40) -> out_data=0x7F, out_sat=1.
REQ-038 Next job after saturation: start, len=1, acc_init=0x00, beat (0x38,0x38) -> out_sat=0, confirming sat clears on start.
REQ-039 Backpressure and stalls: in_valid low 2 cycles mid-job -> acc unchanged; out_ready low 3 cycles -> out_data stable, start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-040 Abort in RUN: after 1 of 3 beats, abort with in_valid=1 -> beat discarded, IDLE next cycle, no out_valid.
REQ-041 rst pulse in OUT: out_valid drops immediately (asynchronous), outputs return to reset values, next start behaves normally.
